// File: rtl/axi_port_bridge.sv
// AXI port bridge: reset synchroniser, outstanding-read/write limiters,
// write-ID FIFO that tags bus W beats, and a sticky bus-error flag.
module axi_port_bridge #(
    parameter int ID_W        = 4,
    parameter int LEN_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_OUTST   = 4,
    parameter int WID_DEPTH   = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    output logic              rst_n_o,
    // core read request
    input  logic [ID_W-1:0]   s_ar_id,
    input  logic [31:0]       s_ar_addr,
    input  logic [LEN_W-1:0]  s_ar_len,
    input  logic [2:0]        s_ar_size,
    input  logic [1:0]        s_ar_burst,
    input  logic              s_ar_valid,
    output logic              s_ar_ready,
    // bus read request
    output logic [ID_W-1:0]   m_ar_id,
    output logic [31:0]       m_ar_addr,
    output logic [7:0]        m_ar_len,
    output logic [2:0]        m_ar_size,
    output logic [1:0]        m_ar_burst,
    output logic              m_ar_valid,
    input  logic              m_ar_ready,
    // read data
    input  logic [ID_W-1:0]   m_r_id,
    input  logic [31:0]       m_r_data,
    input  logic [1:0]        m_r_resp,
    input  logic              m_r_last,
    input  logic              m_r_valid,
    output logic              m_r_ready,
    output logic [ID_W-1:0]   s_r_id,
    output logic [31:0]       s_r_data,
    output logic [1:0]        s_r_resp,
    output logic              s_r_last,
    output logic              s_r_valid,
    input  logic              s_r_ready,
    // core write request
    input  logic [ID_W-1:0]   s_aw_id,
    input  logic [31:0]       s_aw_addr,
    input  logic [LEN_W-1:0]  s_aw_len,
    input  logic [2:0]        s_aw_size,
    input  logic [1:0]        s_aw_burst,
    input  logic              s_aw_valid,
    output logic              s_aw_ready,
    // bus write request
    output logic [ID_W-1:0]   m_aw_id,
    output logic [31:0]       m_aw_addr,
    output logic [7:0]        m_aw_len,
    output logic [2:0]        m_aw_size,
    output logic [1:0]        m_aw_burst,
    output logic              m_aw_valid,
    input  logic              m_aw_ready,
    // write data
    input  logic [31:0]       s_w_data,
    input  logic [3:0]        s_w_strb,
    input  logic              s_w_last,
    input  logic              s_w_valid,
    output logic              s_w_ready,
    output logic [ID_W-1:0]   m_w_id,
    output logic [31:0]       m_w_data,
    output logic [3:0]        m_w_strb,
    output logic              m_w_last,
    output logic              m_w_valid,
    input  logic              m_w_ready,
    // write response
    input  logic [ID_W-1:0]   m_b_id,
    input  logic [1:0]        m_b_resp,
    input  logic              m_b_valid,
    output logic              m_b_ready,
    output logic [ID_W-1:0]   s_b_id,
    output logic [1:0]        s_b_resp,
    output logic              s_b_valid,
    input  logic              s_b_ready,
    output logic              err_o
);

    localparam int PW = (WID_DEPTH > 1) ? $clog2(WID_DEPTH) : 1;
    localparam int CW = $clog2(WID_DEPTH + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [3:0]             rd_cnt, wr_cnt;
    logic [CW-1:0]          fifo_cnt;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [ID_W-1:0]        id_mem [WID_DEPTH];

    logic rd_full, wr_full, fifo_full, fifo_empty;
    logic ar_pass, aw_pass, w_pass;
    logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic rd_dec, wr_dec, push, pop;

    function automatic logic [3:0] cnt_next(input logic [3:0] c, input logic inc,
                                            input logic dec);
        logic [3:0] n;
        n = c;
        if (inc && !dec)
            n = c + 4'd1;
        else if (dec && !inc && c != 4'd0)
            n = c - 4'd1;
        return n;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(WID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_n_o = sync_q[SYNC_STAGES-1];

    // Gating uses only registered state and the s-side valid, so no m_*_ready
    // reaches any m_*_valid.
    assign rd_full    = (rd_cnt == 4'(MAX_OUTST));
    assign wr_full    = (wr_cnt == 4'(MAX_OUTST));
    assign fifo_full  = (fifo_cnt == CW'(WID_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign ar_pass    = rst_n_o & ~rd_full;
    assign aw_pass    = rst_n_o & ~wr_full & ~fifo_full;
    assign w_pass     = rst_n_o & ~fifo_empty;

    assign m_ar_id    = s_ar_id;
    assign m_ar_addr  = s_ar_addr;
    assign m_ar_len   = 8'(s_ar_len);
    assign m_ar_size  = s_ar_size;
    assign m_ar_burst = s_ar_burst;
    assign m_ar_valid = s_ar_valid & ar_pass;
    assign s_ar_ready = m_ar_ready & ar_pass;

    assign m_aw_id    = s_aw_id;
    assign m_aw_addr  = s_aw_addr;
    assign m_aw_len   = 8'(s_aw_len);
    assign m_aw_size  = s_aw_size;
    assign m_aw_burst = s_aw_burst;
    assign m_aw_valid = s_aw_valid & aw_pass;
    assign s_aw_ready = m_aw_ready & aw_pass;

    assign m_w_id     = id_mem[rd_ptr];
    assign m_w_data   = s_w_data;
    assign m_w_strb   = s_w_strb;
    assign m_w_last   = s_w_last;
    assign m_w_valid  = s_w_valid & w_pass;
    assign s_w_ready  = m_w_ready & w_pass;

    assign s_r_id     = m_r_id;
    assign s_r_data   = m_r_data;
    assign s_r_resp   = m_r_resp;
    assign s_r_last   = m_r_last;
    assign s_r_valid  = m_r_valid & rst_n_o;
    assign m_r_ready  = s_r_ready & rst_n_o;

    assign s_b_id     = m_b_id;
    assign s_b_resp   = m_b_resp;
    assign s_b_valid  = m_b_valid & rst_n_o;
    assign m_b_ready  = s_b_ready & rst_n_o;

    assign ar_hs  = s_ar_valid & m_ar_ready & ar_pass;
    assign aw_hs  = s_aw_valid & m_aw_ready & aw_pass;
    assign w_hs   = s_w_valid & m_w_ready & w_pass;
    assign r_hs   = m_r_valid & s_r_ready & rst_n_o;
    assign b_hs   = m_b_valid & s_b_ready & rst_n_o;
    assign rd_dec = r_hs & m_r_last;
    assign wr_dec = b_hs;
    assign push   = aw_hs;
    assign pop    = w_hs & s_w_last;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            err_o    <= 1'b0;
            for (int unsigned i = 0; i < WID_DEPTH; i++)
                id_mem[i] <= '0;
        end else begin
            rd_cnt <= cnt_next(rd_cnt, ar_hs, rd_dec);
            wr_cnt <= cnt_next(wr_cnt, aw_hs, wr_dec);
            if (push) begin
                id_mem[wr_ptr] <= s_aw_id;
                wr_ptr         <= ptr_next(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)
                fifo_cnt <= fifo_cnt + CW'(1);
            else if (pop && !push)
                fifo_cnt <= fifo_cnt - CW'(1);
            if ((r_hs && m_r_resp[1]) || (b_hs && m_b_resp[1]))
                err_o <= 1'b1;
        end
    end

    rd_underflow: assert property (@(posedge aclk) disable iff (!aresetn)
        !(rd_dec && !ar_hs && rd_cnt == 4'd0));
    wr_underflow: assert property (@(posedge aclk) disable iff (!aresetn)
        !(wr_dec && !aw_hs && wr_cnt == 4'd0));

endmodule

// File: tb/tb_axi_port_bridge.sv
// Bench for axi_port_bridge: queue/counter reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_axi_port_bridge;

    localparam int ID_W  = 4;
    localparam int LEN_W = 4;
    localparam int SYNC  = 2;
    localparam int MAX   = 4;
    localparam int DEPTH = 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    logic rst_n_o, err_o;
    logic [ID_W-1:0] s_ar_id, m_ar_id, s_aw_id, m_aw_id, m_w_id;
    logic [31:0] s_ar_addr, m_ar_addr, s_aw_addr, m_aw_addr;
    logic [LEN_W-1:0] s_ar_len, s_aw_len;
    logic [7:0] m_ar_len, m_aw_len;
    logic [2:0] s_ar_size, m_ar_size, s_aw_size, m_aw_size;
    logic [1:0] s_ar_burst, m_ar_burst, s_aw_burst, m_aw_burst;
    logic s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
    logic s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready;
    logic [ID_W-1:0] m_r_id, s_r_id, m_b_id, s_b_id;
    logic [31:0] m_r_data, s_r_data, s_w_data, m_w_data;
    logic [1:0] m_r_resp, s_r_resp, m_b_resp, s_b_resp;
    logic m_r_last, s_r_last, m_r_valid, m_r_ready, s_r_valid, s_r_ready;
    logic [3:0] s_w_strb, m_w_strb;
    logic s_w_last, m_w_last, s_w_valid, s_w_ready, m_w_valid, m_w_ready;
    logic m_b_valid, m_b_ready, s_b_valid, s_b_ready;

    axi_port_bridge #(.ID_W(ID_W), .LEN_W(LEN_W), .SYNC_STAGES(SYNC),
                      .MAX_OUTST(MAX), .WID_DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn), .rst_n_o(rst_n_o),
        .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len),
        .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len),
        .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
        .m_r_last(m_r_last), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .s_r_id(s_r_id), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
        .s_r_last(s_r_last), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
        .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len),
        .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
        .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len),
        .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
        .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
        .m_w_id(m_w_id), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
        .m_w_last(m_w_last), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
        .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_valid(m_b_valid),
        .m_b_ready(m_b_ready),
        .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_valid(s_b_valid),
        .s_b_ready(s_b_ready),
        .err_o(err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding counts, ordered ID queue, error flag,
    // and number of clean edges seen since reset release.
    int              md_rd, md_wr, md_sync;
    bit              md_err;
    logic [ID_W-1:0] md_q[$];

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            md_rd = 0; md_wr = 0; md_sync = 0; md_err = 0;
            md_q.delete();
        end else begin
            bit ok, ar_hs, r_hs, aw_hs, b_hs, pop;
            ok    = (md_sync >= SYNC);
            ar_hs = ok && s_ar_valid && m_ar_ready && md_rd < MAX;
            r_hs  = ok && m_r_valid && s_r_ready;
            aw_hs = ok && s_aw_valid && m_aw_ready && md_wr < MAX && md_q.size() < DEPTH;
            b_hs  = ok && m_b_valid && s_b_ready;
            pop   = ok && s_w_valid && m_w_ready && md_q.size() > 0 && s_w_last;
            md_rd = md_rd + int'(ar_hs) - int'(r_hs && m_r_last);
            if (md_rd < 0) md_rd = 0;
            md_wr = md_wr + int'(aw_hs) - int'(b_hs);
            if (md_wr < 0) md_wr = 0;
            if (pop) void'(md_q.pop_front());
            if (aw_hs) md_q.push_back(s_aw_id);
            if ((r_hs && m_r_resp[1]) || (b_hs && m_b_resp[1])) md_err = 1;
            if (md_sync < SYNC) md_sync++;
        end
    end

    initial begin
        forever begin
            bit ok;
            @(negedge aclk);
            ok = (md_sync >= SYNC);
            chk("rst_n_o", rst_n_o, ok);
            chk("err_o", err_o, md_err);
            chk("s_ar_ready", s_ar_ready, ok && m_ar_ready && md_rd < MAX);
            chk("m_ar_valid", m_ar_valid, ok && s_ar_valid && md_rd < MAX);
            chk("m_ar_len", m_ar_len, {4'b0, s_ar_len});
            chk("m_ar_addr", m_ar_addr, s_ar_addr);
            chk("s_aw_ready", s_aw_ready, ok && m_aw_ready && md_wr < MAX && md_q.size() < DEPTH);
            chk("m_aw_valid", m_aw_valid, ok && s_aw_valid && md_wr < MAX && md_q.size() < DEPTH);
            chk("m_aw_len", m_aw_len, {4'b0, s_aw_len});
            chk("m_w_valid", m_w_valid, ok && s_w_valid && md_q.size() > 0);
            chk("s_w_ready", s_w_ready, ok && m_w_ready && md_q.size() > 0);
            if (md_q.size() > 0) chk("m_w_id", m_w_id, md_q[0]);
            chk("m_w_data", m_w_data, s_w_data);
            chk("s_r_valid", s_r_valid, ok && m_r_valid);
            chk("m_r_ready", m_r_ready, ok && s_r_ready);
            chk("s_r_data", s_r_data, m_r_data);
            chk("s_b_valid", s_b_valid, ok && m_b_valid);
            chk("m_b_ready", m_b_ready, ok && s_b_ready);
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    logic [ID_W-1:0] order_ids [3];

    initial begin
        order_ids = '{4'd3, 4'd7, 4'd1};
        s_ar_id = '0; s_ar_addr = 32'h1000; s_ar_len = '0; s_ar_size = 3'd2;
        s_ar_burst = 2'b01; s_ar_valid = 0;
        s_aw_id = '0; s_aw_addr = 32'h2000; s_aw_len = '0; s_aw_size = 3'd2;
        s_aw_burst = 2'b01; s_aw_valid = 0;
        s_w_data = 32'h0; s_w_strb = 4'hF; s_w_last = 0; s_w_valid = 0;
        m_r_id = '0; m_r_data = 32'hA5A5_0001; m_r_resp = 2'b00; m_r_last = 0; m_r_valid = 0;
        m_b_id = '0; m_b_resp = 2'b00; m_b_valid = 0;
        m_ar_ready = 1; m_aw_ready = 1; m_w_ready = 1; s_r_ready = 1; s_b_ready = 1;
        #1 aresetn = 0;
        repeat (3) tick();

        // reset state
        s_ar_valid = 1; s_aw_valid = 1;
        #1;
        chk("rst_held", rst_n_o, 0);
        chk("err_reset", err_o, 0);
        chk("ar_ready_reset", s_ar_ready, 0);
        chk("ar_valid_reset", m_ar_valid, 0);
        chk("aw_ready_reset", s_aw_ready, 0);
        s_ar_valid = 0; s_aw_valid = 0;
        aresetn = 1;
        tick(); chk("rst_edge1", rst_n_o, 0);
        tick(); chk("rst_edge2", rst_n_o, 1);

        // read limit
        s_ar_valid = 1; s_ar_len = 4'hF; s_ar_id = 4'd2;
        #1 chk("ar_len_ext", m_ar_len, 8'h0F);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ar_ready_%0d", i), s_ar_ready, (i < 4) ? 1 : 0);
            tick();
        end
        m_r_valid = 1; m_r_last = 1; m_r_id = 4'd2;
        #1 chk("ar_blocked_with_r", s_ar_ready, 0);
        tick();
        m_r_valid = 0;
        chk("ar_fifth_accept", s_ar_ready, 1);
        tick();

        // simultaneous AR and R-last at count 3
        s_ar_valid = 0; m_r_valid = 1;
        tick();
        s_ar_valid = 1;
        #1 chk("ar_ready_at3", s_ar_ready, 1);
        tick();
        m_r_valid = 0;
        #1 chk("ar_ready_after_simul", s_ar_ready, 1);
        tick();
        chk("ar_full_again", s_ar_ready, 0);
        s_ar_valid = 0;

        // drain reads, last one SLVERR
        m_r_valid = 1;
        repeat (3) tick();
        m_r_valid = 0;
        #1 chk("err_before", err_o, 0);
        m_r_valid = 1; m_r_resp = 2'b10;
        tick();
        m_r_valid = 0; m_r_resp = 2'b00;
        chk("err_set", err_o, 1);
        repeat (3) tick();
        chk("err_sticky", err_o, 1);

        // write ID order
        s_aw_len = 4'd1;
        for (int k = 0; k < 3; k++) begin
            s_aw_valid = 1; s_aw_id = order_ids[k];
            #1 chk($sformatf("aw_ready_%0d", k), s_aw_ready, 1);
            tick();
            s_aw_valid = 0;
            s_w_valid = 1; s_w_last = 0; s_w_data = 32'h100 + 32'(k);
            #1 chk($sformatf("w_id_%0d_b0", k), m_w_id, order_ids[k]);
            tick();
            s_w_last = 1; s_w_data = 32'h200 + 32'(k);
            #1 chk($sformatf("w_id_%0d_b1", k), m_w_id, order_ids[k]);
            tick();
            s_w_valid = 0; s_w_last = 0;
        end
        s_w_valid = 1;
        #1 chk("w_ready_empty", s_w_ready, 0);
        chk("w_valid_empty", m_w_valid, 0);
        s_w_valid = 0;
        m_b_valid = 1;
        repeat (3) tick();
        m_b_valid = 0;

        // W offered before AW
        s_w_valid = 1; s_w_last = 1; s_w_data = 32'hCAFE_0005;
        #1 chk("w_early_0", s_w_ready, 0);
        tick(); chk("w_early_1", s_w_ready, 0);
        tick();
        s_aw_valid = 1; s_aw_id = 4'd5;
        #1 chk("w_ready_aw_cycle", s_w_ready, 0);
        tick();
        s_aw_valid = 0;
        #1 chk("w_ready_after_aw", s_w_ready, 1);
        chk("w_id_5", m_w_id, 5);
        tick();
        s_w_valid = 0; s_w_last = 0;
        m_b_valid = 1;
        tick();
        m_b_valid = 0;

        // FIFO full, blocked even while popping, then push+pop with wrap
        for (int k = 8; k < 12; k++) begin
            s_aw_valid = 1; s_aw_id = 4'(k);
            tick();
        end
        s_aw_id = 4'd12;
        #1 chk("aw_blocked_full", s_aw_ready, 0);
        m_b_valid = 1;
        tick();
        m_b_valid = 0;
        chk("aw_blocked_fifo", s_aw_ready, 0);
        s_w_valid = 1; s_w_last = 1;
        #1 chk("aw_blocked_on_pop", s_aw_ready, 0);
        chk("w_id_8", m_w_id, 8);
        tick();
        s_w_valid = 0;
        #1 chk("aw_ready_after_pop", s_aw_ready, 1);
        tick();
        s_aw_valid = 0;
        s_w_valid = 1;
        tick();
        s_w_valid = 0; m_b_valid = 1;
        tick();
        m_b_valid = 0;
        s_aw_valid = 1; s_aw_id = 4'd13; s_w_valid = 1;
        #1 chk("w_id_10", m_w_id, 10);
        chk("aw_ready_pushpop", s_aw_ready, 1);
        tick();
        s_aw_valid = 0;
        #1 chk("w_id_11", m_w_id, 11);
        repeat (3) tick();
        s_w_valid = 0; s_w_last = 0;
        #1 chk("w_empty_after_wrap", m_w_valid, 0);
        m_b_valid = 1;
        repeat (4) tick();
        m_b_valid = 0;

        // reset mid-burst
        s_ar_valid = 1;
        repeat (2) tick();
        s_ar_valid = 0; s_aw_valid = 1; s_aw_id = 4'd6;
        tick();
        s_aw_valid = 0;
        s_ar_valid = 1; s_w_valid = 1; s_w_last = 1;
        #2 aresetn = 0;
        #1 chk("rst_async", rst_n_o, 0);
        chk("err_cleared", err_o, 0);
        chk("ar_ready_in_rst", s_ar_ready, 0);
        chk("w_ready_in_rst", s_w_ready, 0);
        tick();
        aresetn = 1;
        #1 chk("ar_ready_rel0", s_ar_ready, 0);
        tick(); chk("ar_ready_rel1", s_ar_ready, 0);
        tick(); chk("rst_rel2", rst_n_o, 1);
        chk("w_ready_fifo_cleared", s_w_ready, 0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ar_ready_post_%0d", i), s_ar_ready, (i < 4) ? 1 : 0);
            tick();
        end
        s_ar_valid = 0; s_w_valid = 0; s_w_last = 0;
        m_r_valid = 1; m_r_last = 1;
        repeat (4) tick();
        m_r_valid = 0;
        tick();
        chk("ar_ready_drained", s_ar_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
